pkd_frame_rx: RTL and testbench
===============================

PKD_FRAME_RX -- requirements
Module: pkd_frame_rx

Interface
REQ-001 Parameter FRAME_NIBS, default 16, nibbles per frame (2..256).
REQ-002 Parameter CNT_W, default 8, nibble counter width; SHALL satisfy 2**CNT_W >= FRAME_NIBS.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  nibble-stream valid.
REQ-006 in_ready  output  1  nibble-stream ready.
REQ-007 in_nib  input  4  nibble payload, 4-state.
REQ-008 in_last  input  1  final nibble of frame marker.
REQ-009 frm_valid  output  1  assembled frame valid.
REQ-010 frm_ready  input  1  frame consumer ready.
REQ-011 frm_data  output  4*FRAME_NIBS  assembled frame; at default, bit-identical to logic [0:3][3:0][4:1].
REQ-012 frm_err  output  3  [0] short frame, [1] long frame, [2] x/z seen.

Function
REQ-013 Nibble transfer SHALL occur on a cycle with in_valid && in_ready.
REQ-014 FSM states SHALL be IDLE, COLLECT, DRAIN, HOLD.
REQ-015 in_ready SHALL be 1 in IDLE, COLLECT, DRAIN; 0 in HOLD.
REQ-016 First nibble of a frame SHALL land in frm_data MSBs (element [0][3] at default); nibble k in bits [4*(FRAME_NIBS-k)-1 -: 4].
REQ-017 IDLE: transfer -> store nibble 0, count=1, COLLECT (or HOLD if in_last or FRAME_NIBS reached).
REQ-018 COLLECT: each transfer stores at position count, count+1.
REQ-019 Transfer with in_last before FRAME_NIBS nibbles -> remaining nibbles zero, frm_err[0]=1, HOLD.
REQ-020 FRAME_NIBS-th transfer with in_last -> HOLD, no length error.
REQ-021 FRAME_NIBS-th transfer without in_last -> frm_err[1]=1, DRAIN.
REQ-022 DRAIN: transfers accepted and discarded; transfer with in_last -> HOLD.
REQ-023 frm_valid SHALL be 1 exactly in HOLD; asserted the cycle after the completing transfer (latency 1).
REQ-024 frm_data, frm_err SHALL be stable throughout HOLD.
REQ-025 HOLD with frm_ready=1 -> IDLE next cycle; no same-cycle nibble acceptance (1 bubble per frame).
REQ-026 Entry to IDLE SHALL clear frm_err and frm_data to 0.
REQ-027 Counter SHALL never wrap; saturates conceptually by leaving COLLECT at FRAME_NIBS.
REQ-028 Nibble storage SHALL preserve x/z values unmodified.

Reset
REQ-029 rst_n low SHALL asynchronously force IDLE, count=0, frm_data=0, frm_err=0, frm_valid=0, in_ready=0 while asserted.
REQ-030 in_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-031 Reset mid-COLLECT or mid-HOLD SHALL discard the partial/held frame; no frm_valid pulse.

Configuration
REQ-032 Macro PKD_FRAME_RX_XZ_CHECK_EN defined: any accepted nibble (including DRAIN) with x or z in any bit SHALL set frm_err[2] for that frame.
REQ-033 Macro undefined: frm_err[2] SHALL be constant 0 and no x/z detection logic built; all other behaviour identical.

Verification
REQ-034 Reset, send 16 nibbles 0x0..0xF, in_last on 16th, frm_ready=1 -> frm_valid 1 cycle later, frm_data=64'h0123_4567_89AB_CDEF, frm_err=0, IDLE next cycle.
REQ-035 Send 0xA,0xB with in_last on 2nd -> frm_data=64'hAB00_0000_0000_0000, frm_err=3'b001.
REQ-036 Send 20 nibbles 0x5, in_last on 20th -> frm_valid after 20th, frm_data=64'h5555_5555_5555_5555, frm_err=3'b010.
REQ-037 Hold frm_ready=0 for 5 cycles during HOLD with in_valid=1 -> in_ready=0, frm_data/frm_err stable, no nibble lost for next frame.
REQ-038 Pull rst_n low after 7 nibbles -> outputs zero immediately; next 16-nibble frame assembles correctly with frm_err=0.
REQ-039 With PKD_FRAME_RX_XZ_CHECK_EN, nibble 3 = 4'b1x0z in a 16-nibble frame -> frm_err=3'b100, nibble preserved in frm_data[51:48]; without macro -> frm_err=3'b000.

Source files
------------

// File: rtl/pkd_frame_rx.sv
// Nibble-stream to frame assembler: packs nibbles MSB-first into a FRAME_NIBS-wide word.
// Optional x/z detection on accepted nibbles (frm_err[2]) when PKD_FRAME_RX_XZ_CHECK_EN is defined.
module pkd_frame_rx #(
   parameter int FRAME_NIBS = 16,
   parameter int CNT_W      = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [3:0]              in_nib,
   input  logic                    in_last,
   output logic                    frm_valid,
   input  logic                    frm_ready,
   output logic [4*FRAME_NIBS-1:0] frm_data,
   output logic [2:0]              frm_err
);

   // state   | meaning
   // IDLE    | no frame in progress, waiting for nibble 0
   // COLLECT | storing nibbles at position cnt_q
   // DRAIN   | frame full, discarding nibbles until in_last
   // HOLD    | frame presented on frm_*, waiting for frm_ready
   typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, HOLD} state_t;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_NIBS - 1);

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [4*FRAME_NIBS-1:0] data_q, data_d;
   logic [1:0]              len_err_q, len_err_d;
   logic                    rdy_en_q;
   logic                    xz_err;
   logic                    xfer;

   // rdy_en_q keeps in_ready low during reset and until the first edge after it.
   assign in_ready  = rdy_en_q && (state_q != HOLD);
   assign xfer      = in_valid && in_ready;
   assign frm_valid = (state_q == HOLD);
   assign frm_data  = data_q;
   assign frm_err   = {xz_err, len_err_q};

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      data_d    = data_q;
      len_err_d = len_err_q;
      case (state_q)
         IDLE, COLLECT: begin
            if (xfer) begin
               for (int k = 0; k < FRAME_NIBS; k++) begin
                  if (cnt_q == CNT_W'(k)) data_d[4*(FRAME_NIBS-1-k) +: 4] = in_nib;
               end
               if (cnt_q == LAST_IDX) begin
                  if (in_last) begin
                     state_d = HOLD;
                  end else begin
                     len_err_d[1] = 1'b1;
                     state_d      = DRAIN;
                  end
               end else if (in_last) begin
                  len_err_d[0] = 1'b1;
                  state_d      = HOLD;
               end else begin
                  cnt_d   = cnt_q + CNT_W'(1);
                  state_d = COLLECT;
               end
            end
         end
         DRAIN: begin
            if (xfer && in_last) state_d = HOLD;
         end
         HOLD: begin
            if (frm_ready) begin
               state_d   = IDLE;
               cnt_d     = '0;
               data_d    = '0;
               len_err_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         data_q    <= '0;
         len_err_q <= '0;
         rdy_en_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         data_q    <= data_d;
         len_err_q <= len_err_d;
         rdy_en_q  <= 1'b1;
      end
   end

`ifdef PKD_FRAME_RX_XZ_CHECK_EN
   logic xz_q, xz_d;

   // Any accepted nibble counts, including those discarded in DRAIN.
   always_comb begin
      xz_d = xz_q;
      if (xfer && $isunknown(in_nib)) xz_d = 1'b1;
      if (state_q == HOLD && frm_ready) xz_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) xz_q <= 1'b0;
      else        xz_q <= xz_d;
   end

   assign xz_err = xz_q;
`else
   assign xz_err = 1'b0;
`endif

endmodule

// File: tb/tb_pkd_frame_rx.sv
// Self-checking bench for pkd_frame_rx: directed frames plus randomized frames
// checked against a frame-level reference model (nibble list -> word + error flags).
module tb_pkd_frame_rx;
   localparam int FN = 16;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [3:0]      in_nib = 4'h0;
   logic            in_last = 1'b0;
   logic            frm_valid;
   logic            frm_ready = 1'b0;
   logic [4*FN-1:0] frm_data;
   logic [2:0]      frm_err;

   int vecs = 0;
   int errs = 0;
   logic [3:0] fq[$];

   pkd_frame_rx dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_nib(in_nib), .in_last(in_last),
      .frm_valid(frm_valid), .frm_ready(frm_ready), .frm_data(frm_data), .frm_err(frm_err)
   );

   always #5 clk = ~clk;

   // Reference model: first FN nibbles of the frame, MSB first, rest zero.
   function automatic logic [4*FN-1:0] model_data();
      logic [4*FN-1:0] d = '0;
      for (int k = 0; k < fq.size() && k < FN; k++) d[4*(FN-1-k) +: 4] = fq[k];
      return d;
   endfunction

   function automatic logic [2:0] model_err();
      logic xz = 1'b0;
`ifdef PKD_FRAME_RX_XZ_CHECK_EN
      foreach (fq[k]) if ($isunknown(fq[k])) xz = 1'b1;
`endif
      return {xz, fq.size() > FN, fq.size() < FN};
   endfunction

   // All tasks start and end at 1 time unit after a rising edge.
   task automatic send_frame(input bit gaps, input bit with_last);
      for (int i = 0; i < fq.size(); i++) begin
         if (gaps && i > 0 && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         in_nib   = fq[i];
         in_last  = with_last && (i == fq.size() - 1);
         vecs++;
         if (in_ready !== 1'b1 || frm_valid !== 1'b0) begin
            errs++;
            $display("FAIL accept nib%0d: in_ready=%b frm_valid=%b, required 1/0", i, in_ready, frm_valid);
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic check_frame(input string tag);
      logic [4*FN-1:0] ed;
      logic [2:0]      ee;
      ed = model_data();
      ee = model_err();
      vecs++;
      if (frm_valid !== 1'b1) begin
         errs++;
         $display("FAIL %s frm_valid: got %b, required 1", tag, frm_valid);
      end
      vecs++;
      if (frm_data !== ed) begin
         errs++;
         $display("FAIL %s frm_data: got %h, required %h", tag, frm_data, ed);
      end
      vecs++;
      if (frm_err !== ee) begin
         errs++;
         $display("FAIL %s frm_err: got %b, required %b", tag, frm_err, ee);
      end
   endtask

   task automatic release_frame(input int hold, input bit keep_valid, input logic [3:0] next_nib);
      logic [4*FN-1:0] ed;
      logic [2:0]      ee;
      ed = model_data();
      ee = model_err();
      frm_ready = 1'b0;
      if (keep_valid) begin
         in_valid = 1'b1;
         in_nib   = next_nib;
         in_last  = 1'b0;
      end
      for (int c = 0; c < hold; c++) begin
         @(posedge clk); #1;
         vecs++;
         if (frm_valid !== 1'b1 || in_ready !== 1'b0 || frm_data !== ed || frm_err !== ee) begin
            errs++;
            $display("FAIL hold cyc%0d: valid=%b ready=%b data=%h err=%b, required 1 0 %h %b",
                     c, frm_valid, in_ready, frm_data, frm_err, ed, ee);
         end
      end
      frm_ready = 1'b1;
      @(posedge clk); #1;
      frm_ready = 1'b0;
      vecs++;
      if (frm_valid !== 1'b0 || in_ready !== 1'b1 || frm_data !== '0 || frm_err !== 3'b000) begin
         errs++;
         $display("FAIL release: valid=%b ready=%b data=%h err=%b, required 0 1 0 000",
                  frm_valid, in_ready, frm_data, frm_err);
      end
   endtask

   task automatic test_reset();
      in_valid = 1'b1;
      #3;
      vecs++;
      if (in_ready !== 1'b0 || frm_valid !== 1'b0 || frm_data !== '0 || frm_err !== 3'b000) begin
         errs++;
         $display("FAIL reset outputs: ready=%b valid=%b data=%h err=%b, required all 0",
                  in_ready, frm_valid, frm_data, frm_err);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      vecs++;
      if (in_ready !== 1'b0) begin
         errs++;
         $display("FAIL ready before first edge: got %b, required 0", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      vecs++;
      if (in_ready !== 1'b1 || frm_valid !== 1'b0) begin
         errs++;
         $display("FAIL ready after first edge: ready=%b valid=%b, required 1/0", in_ready, frm_valid);
      end
   endtask

   task automatic test_basic();
      fq.delete();
      for (int i = 0; i < FN; i++) fq.push_back(4'(i));
      send_frame(1'b0, 1'b1);
      check_frame("basic");
      vecs++;
      if (frm_data !== 64'h0123_4567_89AB_CDEF) begin
         errs++;
         $display("FAIL basic const: got %h, required 0123456789abcdef", frm_data);
      end
      release_frame(0, 1'b0, 4'h0);
   endtask

   task automatic test_short();
      fq.delete();
      fq.push_back(4'hA);
      fq.push_back(4'hB);
      send_frame(1'b0, 1'b1);
      check_frame("short");
      vecs++;
      if (frm_data !== 64'hAB00_0000_0000_0000 || frm_err !== 3'b001) begin
         errs++;
         $display("FAIL short const: got %h/%b, required ab00000000000000/001", frm_data, frm_err);
      end
      release_frame(1, 1'b0, 4'h0);
   endtask

   task automatic test_long();
      fq.delete();
      for (int i = 0; i < 20; i++) fq.push_back(4'h5);
      send_frame(1'b0, 1'b1);
      check_frame("long");
      vecs++;
      if (frm_data !== 64'h5555_5555_5555_5555 || frm_err !== 3'b010) begin
         errs++;
         $display("FAIL long const: got %h/%b, required 5555555555555555/010", frm_data, frm_err);
      end
      release_frame(0, 1'b0, 4'h0);
   endtask

   task automatic test_back_to_back();
      logic [3:0] nxt[$];
      fq.delete();
      for (int i = 0; i < FN; i++) fq.push_back(4'($urandom));
      for (int i = 0; i < FN; i++) nxt.push_back(4'($urandom));
      send_frame(1'b0, 1'b1);
      check_frame("b2b first");
      release_frame(5, 1'b1, nxt[0]);
      fq = nxt;
      send_frame(1'b0, 1'b1);
      check_frame("b2b second");
      release_frame(0, 1'b0, 4'h0);
   endtask

   task automatic test_mid_reset();
      fq.delete();
      for (int i = 0; i < 7; i++) fq.push_back(4'($urandom));
      send_frame(1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      vecs++;
      if (in_ready !== 1'b0 || frm_valid !== 1'b0 || frm_data !== '0 || frm_err !== 3'b000) begin
         errs++;
         $display("FAIL mid-collect reset: ready=%b valid=%b data=%h err=%b, required all 0",
                  in_ready, frm_valid, frm_data, frm_err);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         vecs++;
         if (frm_valid !== 1'b0) begin
            errs++;
            $display("FAIL post-reset valid cyc%0d: got %b, required 0", c, frm_valid);
         end
      end
      fq.delete();
      for (int i = 0; i < FN; i++) fq.push_back(4'($urandom));
      send_frame(1'b1, 1'b1);
      check_frame("after reset");
      rst_n = 1'b0;
      #1;
      vecs++;
      if (frm_valid !== 1'b0 || frm_data !== '0 || frm_err !== 3'b000) begin
         errs++;
         $display("FAIL mid-hold reset: valid=%b data=%h err=%b, required all 0",
                  frm_valid, frm_data, frm_err);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      vecs++;
      if (frm_valid !== 1'b0 || in_ready !== 1'b1) begin
         errs++;
         $display("FAIL after hold reset: valid=%b ready=%b, required 0/1", frm_valid, in_ready);
      end
   endtask

   task automatic test_xz();
      logic [3:0] bad;
      bad = 4'b1x0z;
      fq.delete();
      for (int i = 0; i < FN; i++) fq.push_back(4'($urandom));
      fq[3] = bad;
      send_frame(1'b0, 1'b1);
      check_frame("xz");
      vecs++;
      if (frm_data[51:48] !== bad) begin
         errs++;
         $display("FAIL xz nibble: got %b, required %b", frm_data[51:48], bad);
      end
      release_frame(0, 1'b0, 4'h0);
   endtask

   task automatic test_random();
      for (int f = 0; f < 40; f++) begin
         int n;
         n = $urandom_range(1, 22);
         fq.delete();
         for (int i = 0; i < n; i++) fq.push_back(4'($urandom));
         send_frame(1'b1, 1'b1);
         check_frame($sformatf("rand%0d", f));
         release_frame($urandom_range(0, 3), 1'b0, 4'h0);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_short();
      test_long();
      test_back_to_back();
      test_mid_reset();
      test_xz();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
